serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial, multi-cycle adder for the basic workflow datapath. It is the downstream consumer of the team's half_adder cell.
- Adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell built from two half_adder instances and a registered carry.
- Uses a start/busy/done handshake toward the controlling logic.
- Trades latency for area, reusing the verified half-adder cell as its only arithmetic.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range is WIDTH >= 1.
- CNT_W, $clog2(WIDTH)+1, bit-counter width. This is derived and must not be overridden.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request to add a and b. Sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- busy  output  1  high while in ADD or DONE.
- done  output  1  one-cycle pulse: sum/carry_out are valid.
- sum  output  WIDTH  registered result; holds until the next completion.
- carry_out  output  1  registered carry out of the MSB; holds with sum.

Behaviour:
- Reset: rst high asynchronously forces the following, regardless of clock:
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, carry_out = 0
  - internal shift registers, carry flop and bit counter = 0
- Reset mid-operation aborts the add. No done pulse follows, and after release the block sits in IDLE.
- FSM states: IDLE, ADD, DONE. Encodings come from the shared include file.
- IDLE:
  - When start = 1 at an edge: latch a and b into shift registers sa and sb, clear carry and counter, go to ADD.
  - When start = 0: stay in IDLE.
- ADD, each edge:
  - bit = sa[0] ^ sb[0] ^ c
  - c <= majority(sa[0], sb[0], c)
  - Shift bit into result shift register rs from the MSB side; shift sa and sb right by one.
  - cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1 (the final bit): go to DONE, and load sum <= final rs value and carry_out <= final carry in the same edge.
- DONE: done = 1 for exactly one cycle, then unconditionally back to IDLE.
- Latency: start accepted at edge k; done is high in the cycle after edge k+WIDTH. Total is WIDTH+1 edges from acceptance to the return to IDLE.
- Throughput: a new start is accepted at the earliest in the cycle after done, i.e. in IDLE.
- start is ignored while busy = 1. It is not queued and has no effect on the add in flight.
- Changing a or b after acceptance has no effect on the add in flight.
- sum and carry_out change only on the DONE-entry edge (and on reset). They are stable through ADD and held in IDLE indefinitely.
- busy = 1 exactly in ADD and DONE. busy and done are registered outputs with no combinational paths from the inputs.
- Arithmetic: {carry_out, sum} == a + b, computed modulo 2^(WIDTH+1). There is no signed interpretation.
- WIDTH = 1: ADD lasts one edge, and done appears in the cycle after edge k+1.
- A start asserted on the same edge that rst deasserts is not accepted. rst has priority.

Decomposition:
- Shared include adder_defs.vh holds:
  - FSM state localparams IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2
  - default WIDTH
- Sub-module full_adder (a, b, cin -> sum, cout) is built from two half_adder instances plus an OR on their carries. serial_adder instantiates exactly one full_adder for the per-bit step.
- The counter, shift registers and FSM stay in serial_adder.

Test Plan:
- WIDTH=8. rst pulse, then start with a=0x00, b=0x00 -> done after 8 edges; sum=0x00, carry_out=0. Check busy=1 for 9 cycles.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1. a=0xA5, b=0x5A -> sum=0xFF, carry_out=0. a=0xFF, b=0xFF -> sum=0xFE, carry_out=1.
- a=0x3C, b=0x0F, then assert start with a=0x01, b=0x01 and change a/b mid-ADD -> only one done pulse; sum=0x4B, carry_out=0.
- a=0x80, b=0x80; assert rst after 4 ADD edges -> immediately busy=0, done=0, sum=0x00, carry_out=0. No done follows. A fresh start with 0x80+0x80 gives sum=0x00, carry_out=1.
- WIDTH=1 instance, all four (a,b) pairs -> {carry_out, sum} = 00, 01, 01, 10, each with done one cycle after the ADD edge.
- Random: 1000 back-to-back adds, each start issued on the first IDLE cycle -> {carry_out, sum} == a+b every time, and sum is stable between done pulses.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and
// the default operand width.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/half_adder.sv
// Half-adder cell: one-bit sum and carry of two inputs.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/serial_adder_full_adder.sv
// Full adder built from two half-adder cells; the two partial carries
// can never both be set, so an OR merges them.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha0 (
      .a     (a),
      .b     (b),
      .sum   (s1),
      .carry (c1)
   );

   half_adder u_ha1 (
      .a     (s1),
      .b     (cin),
      .sum   (sum),
      .carry (c2)
   );

   assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per
// clock, through a single full adder and a registered carry.
//
// Handshake: start is sampled only while idle (busy = 0); the edge that
// sees start = 1 in IDLE captures a and b. busy stays high from that edge
// until the cycle after the done pulse. done is a one-cycle pulse during
// which sum/carry_out are valid; they then hold until the next completion.
// start while busy is ignored (not queued).
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic [1:0]       state_dbg
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   sa;
   logic [WIDTH-1:0]   sb;
   logic [WIDTH-1:0]   rs;
   logic [WIDTH-1:0]   rs_next;
   logic               c;
   logic [CNT_W-1:0]   cnt;
   logic               last_bit;
   logic               fa_sum;
   logic               fa_cout;

   // One full adder does all the arithmetic, one bit per ADD cycle.
   full_adder u_fa (
      .a    (sa[0]),
      .b    (sb[0]),
      .cin  (c),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   // New result bit enters from the MSB side; the LSB falls off.
   assign rs_next  = WIDTH'({fa_sum, rs} >> 1);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = ADD;
         ADD:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: operand capture, serial shifting, and result load on the final bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa        <= '0;
         sb        <= '0;
         rs        <= '0;
         c         <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa  <= a;
                  sb  <= b;
                  rs  <= '0;
                  c   <= 1'b0;
                  cnt <= '0;
               end
            end
            ADD: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               rs  <= rs_next;
               c   <= fa_cout;
               cnt <= cnt + CNT_W'(1);
               if (last_bit) begin
                  sum       <= rs_next;
                  carry_out <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs decode the state register only, so they carry no input paths.
   assign busy      = (state == ADD) || (state == DONE);
   assign done      = (state == DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases at WIDTH=8 and
// WIDTH=1, then randomized back-to-back adds against a plain a+b model.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst;

   // WIDTH = 8 instance
   logic       start8;
   logic [7:0] a8, b8;
   logic       busy8, done8, co8;
   logic [7:0] sum8;
   logic [1:0] st8;

   // WIDTH = 1 instance
   logic       start1;
   logic [0:0] a1, b1;
   logic       busy1, done1, co1;
   logic [0:0] sum1;
   logic [1:0] st1;

   int n_pass  = 0;
   int n_total = 0;

   logic [8:0] exp_q[$];
   logic [8:0] held;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .start     (start8),
      .a         (a8),
      .b         (b8),
      .busy      (busy8),
      .done      (done8),
      .sum       (sum8),
      .carry_out (co8),
      .state_dbg (st8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .start     (start1),
      .a         (a1),
      .b         (b1),
      .busy      (busy1),
      .done      (done1),
      .sum       (sum1),
      .carry_out (co1),
      .state_dbg (st1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One WIDTH=8 add; poke keeps start high and wiggles a/b during ADD.
   task automatic do_add(input logic [7:0] x, input logic [7:0] y, input bit poke);
      int cyc;
      int busy_n;
      logic [8:0] exp;
      cyc = 0;
      while (busy8 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      if (busy8) check("idle_timeout", 32'(busy8), 32'd0);
      exp_q.push_back({1'b0, x} + {1'b0, y});
      start8 = 1'b1;
      a8 = x;
      b8 = y;
      @(negedge clk);
      if (poke) begin
         a8 = 8'h01;
         b8 = 8'h01;
      end else begin
         start8 = 1'b0;
         a8 = 8'($urandom);
         b8 = 8'($urandom);
      end
      busy_n = 0;
      cyc = 0;
      while (!done8 && cyc < 40) begin
         if (busy8) busy_n++;
         check("hold", 32'({co8, sum8}), 32'(held));
         @(negedge clk);
         cyc++;
         if (poke && cyc == 4) start8 = 1'b0;
         else if (poke) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
         end
      end
      check("done_latency", 32'(cyc), 32'd8);
      if (busy8) busy_n++;
      check("busy_cycles", 32'(busy_n), 32'd9);
      exp = exp_q.pop_front();
      check("sum", 32'({co8, sum8}), 32'(exp));
      held = exp;
      @(negedge clk);
      check("done_pulse", 32'(done8), 32'd0);
      check("back_idle", 32'(busy8), 32'd0);
   endtask

   initial begin
      int n_done;
      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0;
      start1 = 1'b0; a1 = '0; b1 = '0;
      held = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_sum", 32'({co8, sum8}), 32'd0);
      check("rst_state", 32'(st8), 32'd0);
      check("rst_w1", 32'({busy1, done1, co1, sum1}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed WIDTH=8 cases
      do_add(8'h00, 8'h00, 1'b0);
      do_add(8'hFF, 8'h01, 1'b0);
      do_add(8'hA5, 8'h5A, 1'b0);
      do_add(8'hFF, 8'hFF, 1'b0);
      do_add(8'h3C, 8'h0F, 1'b1);
      n_done = 0;
      repeat (12) begin
         if (done8) n_done++;
         @(negedge clk);
      end
      check("no_extra_done", 32'(n_done), 32'd0);

      // Reset in the middle of an add
      start8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_busy", 32'(busy8), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy8), 32'd0);
      check("mid_rst_done", 32'(done8), 32'd0);
      check("mid_rst_sum", 32'({co8, sum8}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      held = '0;
      n_done = 0;
      repeat (15) begin
         if (done8 || busy8) n_done++;
         @(negedge clk);
      end
      check("abort_quiet", 32'(n_done), 32'd0);
      do_add(8'h80, 8'h80, 1'b0);

      // WIDTH=1: all four operand pairs
      for (int i = 0; i < 4; i++) begin
         logic [1:0] pr;
         logic [1:0] exp1;
         pr = 2'(i);
         exp1 = {1'b0, pr[1]} + {1'b0, pr[0]};
         start1 = 1'b1; a1 = pr[1]; b1 = pr[0];
         @(negedge clk);
         start1 = 1'b0;
         check("w1_add_busy", 32'(busy1), 32'd1);
         check("w1_add_nodone", 32'(done1), 32'd0);
         @(negedge clk);
         check("w1_done", 32'(done1), 32'd1);
         check("w1_sum", 32'({co1, sum1}), 32'(exp1));
         @(negedge clk);
         check("w1_idle", 32'(busy1), 32'd0);
      end

      // Random back-to-back adds
      for (int i = 0; i < 1000; i++) begin
         do_add(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
